// File: rtl/fnd_scan_controller_if.sv
// Datapath-side and pin-side signals of the FND scan controller.
// master = value source (drives i_*); slave = scan controller (drives o_*).
interface fnd_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    i_en;
    logic [4*NUM_DIGITS-1:0] i_value;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_blank_lz;
    logic [NUM_DIGITS-1:0]   o_digit;
    logic [7:0]              o_seg;
    logic [POS_W-1:0]        o_position;
    logic                    o_scan_tick;

    modport master (
        output i_en, i_value, i_dp, i_blank_lz,
        input  o_digit, o_seg, o_position, o_scan_tick
    );

    modport slave (
        input  i_en, i_value, i_dp, i_blank_lz,
        output o_digit, o_seg, o_position, o_scan_tick
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scan: frame-latched value, ghost blanking, leading-zero blanking.
// Outputs registered (1-cycle latency); no backpressure, free-running while i_en=1.
module fnd_scan_controller #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 100000,
    parameter int BLANK_CYCLES     = 2,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fnd_scan_controller_if.slave bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIGIT_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [4*NUM_DIGITS-1:0] frame_value_q, frame_value_d;
    logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic [7:0]              seg_q, seg_d;
    logic [POS_W-1:0]        position_q, position_d;
    logic                    tick_q, tick_d;

    logic [3:0] nib;
    logic       dp_bit;
    logic       hi_zero;
    logic       lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q         <= '0;
            pos_q         <= '0;
            frame_value_q <= '0;
            frame_dp_q    <= '0;
            digit_q       <= DIG_OFF;
            seg_q         <= SEG_OFF;
            position_q    <= '0;
            tick_q        <= 1'b0;
        end else begin
            div_q         <= div_d;
            pos_q         <= pos_d;
            frame_value_q <= frame_value_d;
            frame_dp_q    <= frame_dp_d;
            digit_q       <= digit_d;
            seg_q         <= seg_d;
            position_q    <= position_d;
            tick_q        <= tick_d;
        end
    end

    // Frame is captured only at the first clock of slot 0 so a digit never tears mid-frame.
    always_comb begin
        div_d         = div_q;
        pos_d         = pos_q;
        frame_value_d = frame_value_q;
        frame_dp_d    = frame_dp_q;
        tick_d        = 1'b0;
        if (!bus.i_en) begin
            div_d = '0;
            pos_d = '0;
        end else begin
            if (div_q == '0 && pos_q == '0) begin
                frame_value_d = bus.i_value;
                frame_dp_d    = bus.i_dp;
            end
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
                pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        nib     = 4'h0;
        dp_bit  = 1'b0;
        hi_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (POS_W'(k) == pos_q) begin
                nib    = frame_value_q[4*k +: 4];
                dp_bit = frame_dp_q[k];
            end
            if (POS_W'(k) >= pos_q && frame_value_q[4*k +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end
        lz_blank   = bus.i_blank_lz && (pos_q != '0) && hi_zero && !dp_bit;
        digit_d    = DIG_OFF;
        seg_d      = SEG_OFF;
        position_d = bus.i_en ? pos_q : '0;
        if (bus.i_en && div_q >= BLANK_END && !lz_blank) begin
            digit_d = DIG_OFF ^ (NUM_DIGITS'(1) << pos_q);
            seg_d   = SEG_OFF ^ {dp_bit, hex7(nib)};
        end
    end

    assign bus.o_digit     = digit_q;
    assign bus.o_seg       = seg_q;
    assign bus.o_position  = position_q;
    assign bus.o_scan_tick = tick_q;
endmodule
